tennis_score_keeper: RTL and testbench
======================================

# tennis_score_keeper

Upstream score stage for the seven-segment score display. It takes the three raw push-buttons (point for player 0, point for player 1, new game) and synchronises and debounces each one. It tracks one game to 3 points and drives the 2-bit `p0`/`p1` score buses consumed by the display stage. Once a player reaches 3, the scores freeze until a new game is started, so the display never receives the illegal 3–3 combination.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: number of consecutive stable synchronised samples required before a debounced button level changes (10 ms at 100 MHz). Legal range ≥ 1.
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: asynchronous, active-low reset. The clock is single; reset is asynchronous and active-low.
- `btn0` input 1: raw, asynchronous, bouncy button. A press scores a point for player 0.
- `btn1` input 1: raw button. A press scores a point for player 1.
- `btn_new` input 1: raw button. A press clears both scores and starts a new game.
- `p0` output 2: player 0 score, 0..3, registered.
- `p1` output 2: player 1 score, 0..3, registered.
- `game_over` output 1: high while in state OVER, registered.
- `winner` output 1: 0 means player 0 won, 1 means player 1 won. Valid only while `game_over` is high; otherwise 0.

## Operation
- Per button, the front end is three stages:
  - 2-flop synchroniser. Flops reset to 0.
  - Debouncer:
    - Counter width is $clog2(DEBOUNCE_CYCLES+1).
    - When the synchroniser output equals the debounced level, the counter clears to 0.
    - Otherwise the counter increments.
    - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter clears.
    - The debounced level resets to 0.
  - Rising-edge detector. It emits a 1-cycle pulse (`pt0`, `pt1`, `newg`) on the cycle the debounced level goes 0→1. Release (1→0) produces nothing.
- The game FSM has two states, PLAY and OVER. Reset state is PLAY.
- Event priority within one cycle:
  1. `newg`: in either state, `p0` and `p1` become 0, `game_over` and `winner` become 0, and the state becomes PLAY. Any `pt0`/`pt1` in the same cycle is discarded.
  2. In PLAY, `pt0` and `pt1` both high: neither player scores and there is no state change.
  3. In PLAY, `pt0` alone: `p0` increments by 1. If the new value is 3, the state becomes OVER, `game_over` becomes 1, and `winner` becomes 0.
  4. In PLAY, `pt1` alone: symmetric with item 3, with `winner` becoming 1.
  5. In OVER: `pt0` and `pt1` are ignored, and scores hold.
- Scores never exceed 3 and never wrap. A 3–3 state is unreachable.
- Holding a button produces exactly one point. Bounces shorter than DEBOUNCE_CYCLES produce no point.
- Reset mid-debounce or mid-game:
  - Synchronisers, counters, debounced levels, and edge state clear.
  - A button physically held through reset release is seen as a fresh press once it is stable for DEBOUNCE_CYCLES.

## Timing
- Reset values: `p0`=0, `p1`=0, `game_over`=0, `winner`=0, state PLAY.
- Latency from a clean raw rising edge to the updated score output is 2 + DEBOUNCE_CYCLES + 1 rising clock edges:
  - 2 edges through the synchroniser.
  - DEBOUNCE_CYCLES edges for the counter to reach its limit; the debounced level changes on that edge.
  - 1 edge for the FSM/score registers to absorb the pulse.
- `game_over` and `winner` change on the same edge as the final score update.
- A minimum of 2·DEBOUNCE_CYCLES cycles separates two accepted presses of the same button: stable high, then stable low.
- Outputs are fully registered. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: hold `rst`=0 while toggling all buttons. Required: `p0`=`p1`=0, `game_over`=0. After release, with no presses, outputs hold.
- Clean press: raise `btn0` and hold it for 20 cycles. Required: `p0` goes 0→1 exactly 7 edges after the first sampling edge and stays 1. Releasing `btn0` does not change it.
- Bounce: toggle `btn1` every 2 cycles for 16 cycles, then return it low. Required: `p1` stays 0.
- Win and lockout: press `btn1` 3 times cleanly. Required: `p1` = 1, 2, 3, with `game_over`=1 and `winner`=1 on the third update. A further `btn0` or `btn1` press leaves `p0`=0, `p1`=3.
- Simultaneous and priority: press `btn0` and `btn1` on the same edge. Required: no score change. Press `btn_new` together with `btn0` at score 2–1. Required: both scores become 0 and `game_over`=0.
- Reset mid-game: at 2–2 with a `btn0` press half-debounced (counter=2), assert `rst`. Required: immediately 0–0. After release, with `btn0` still held, `p0`=1 exactly 7 edges later.

Source files
------------

// File: rtl/tennis_score_keeper.sv
// tennis_score_keeper: button front end (synchroniser, debouncer, rising-edge
// detector) feeding a two-state game FSM that keeps one game to 3 points.
// The scores freeze once a player reaches 3, so the display never sees 3-3.
module tennis_score_keeper #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn0,
  input  logic       btn1,
  input  logic       btn_new,
  output logic [1:0] p0,
  output logic [1:0] p1,
  output logic       game_over,
  output logic       winner
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The level flips on the edge where the counter would reach DEBOUNCE_CYCLES,
  // so the compare value is one below it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

  // Bit 0: player 0 point, bit 1: player 1 point, bit 2: new game
  logic [2:0] btn_raw;
  logic [2:0] pulse;
  logic       pt0;
  logic       pt1;
  logic       newg;

  assign btn_raw = {btn_new, btn1, btn0};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic             sync1_reg;
      logic             sync2_reg;
      logic             level_reg;
      logic             level_d_reg;
      logic [CNT_W-1:0] cnt_reg;

      // Two-flop synchroniser for the raw asynchronous button
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
        end
      end

      // Debouncer: level follows the synchronised input only after it has
      // disagreed with the level for DEBOUNCE_CYCLES consecutive samples
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          level_reg <= 1'b0;
          cnt_reg   <= '0;
        end else if (sync2_reg == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          level_reg <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      // Delayed copy of the debounced level for rising-edge detection
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          level_d_reg <= 1'b0;
        end else begin
          level_d_reg <= level_reg;
        end
      end

      assign pulse[gi] = level_reg & ~level_d_reg;
    end
  endgenerate

  assign pt0  = pulse[0];
  assign pt1  = pulse[1];
  assign newg = pulse[2];

  state_t     state_reg;
  state_t     state_next;
  logic [1:0] p0_reg;
  logic [1:0] p0_next;
  logic [1:0] p1_reg;
  logic [1:0] p1_next;
  logic       winner_reg;
  logic       winner_next;

  // Game state and score registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= PLAY;
      p0_reg     <= 2'd0;
      p1_reg     <= 2'd0;
      winner_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      p0_reg     <= p0_next;
      p1_reg     <= p1_next;
      winner_reg <= winner_next;
    end
  end

  // Next-state logic: new game beats everything; a tie of points scores nothing
  always_comb begin
    state_next  = state_reg;
    p0_next     = p0_reg;
    p1_next     = p1_reg;
    winner_next = winner_reg;
    if (newg) begin
      state_next  = PLAY;
      p0_next     = 2'd0;
      p1_next     = 2'd0;
      winner_next = 1'b0;
    end else if (state_reg == PLAY) begin
      if (pt0 && !pt1 && p0_reg != 2'd3) begin
        p0_next = p0_reg + 2'd1;
        if (p0_reg == 2'd2) begin
          state_next  = OVER;
          winner_next = 1'b0;
        end
      end else if (pt1 && !pt0 && p1_reg != 2'd3) begin
        p1_next = p1_reg + 2'd1;
        if (p1_reg == 2'd2) begin
          state_next  = OVER;
          winner_next = 1'b1;
        end
      end
    end
  end

  assign p0        = p0_reg;
  assign p1        = p1_reg;
  assign game_over = (state_reg == OVER);
  assign winner    = winner_reg;

endmodule

// File: tb/tb_tennis_score_keeper.sv
// tb_tennis_score_keeper: directed presses with hand-computed score updates.
// Stimulus pushes the expected output change (with its arrival cycle) into a
// queue; a monitor pops and compares whenever the DUT outputs change.
module tb_tennis_score_keeper;

  localparam int DEB = 4;
  localparam int LAT = 2 + DEB + 1;

  typedef struct {
    int         cyc;
    logic [1:0] p0;
    logic [1:0] p1;
    logic       go;
    logic       win;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] btn_vec;
  logic [1:0] p0;
  logic [1:0] p1;
  logic       game_over;
  logic       winner;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   failures;
  bit   mon_en;
  logic [5:0] prev_out;

  tennis_score_keeper #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn0     (btn_vec[0]),
    .btn1     (btn_vec[1]),
    .btn_new  (btn_vec[2]),
    .p0       (p0),
    .p1       (p1),
    .game_over(game_over),
    .winner   (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter; stimulus reads it 2 ns after the edge
  initial cyc = 0;
  always @(posedge clk) cyc++;

  // Monitor: every output change must match the next queued expectation
  always @(negedge clk) begin
    logic [5:0] cur;
    exp_t       e;
    cur = {p0, p1, game_over, winner};
    if (mon_en && cur !== prev_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cyc=%0d got p0=%0d p1=%0d go=%0b win=%0b, none required",
                 cyc, p0, p1, game_over, winner);
      end else begin
        e = exp_q.pop_front();
        if (cur !== {e.p0, e.p1, e.go, e.win} || cyc != e.cyc) begin
          failures++;
          $display("FAIL score_update got cyc=%0d p0=%0d p1=%0d go=%0b win=%0b, required cyc=%0d p0=%0d p1=%0d go=%0b win=%0b",
                   cyc, p0, p1, game_over, winner, e.cyc, e.p0, e.p1, e.go, e.win);
        end else begin
          $display("txn cyc=%0d p0=%0d p1=%0d go=%0b win=%0b ok", cyc, p0, p1, game_over, winner);
        end
      end
    end
    prev_out = cur;
  end

  task automatic check_val(input string name, input logic [1:0] got, input logic [1:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end else begin
      $display("txn check %s = %0d ok", name, got);
    end
  endtask

  task automatic check_score(input string name, input logic [1:0] r0, input logic [1:0] r1,
                             input logic rgo, input logic rwin);
    check_val({name, "_p0"}, p0, r0);
    check_val({name, "_p1"}, p1, r1);
    check_val({name, "_go"}, {1'b0, game_over}, {1'b0, rgo});
    check_val({name, "_win"}, {1'b0, winner}, {1'b0, rwin});
  endtask

  // Every queued expectation must have been consumed within a bounded wait
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got %0d pending updates required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Clean press of the buttons in mask; optionally queue the resulting outputs
  task automatic press(input string name, input logic [2:0] mask, input bit change,
                       input logic [1:0] r0, input logic [1:0] r1, input logic rgo, input logic rwin);
    exp_t e;
    @(posedge clk);
    #2;
    btn_vec = btn_vec | mask;
    if (change) begin
      e.cyc = cyc + LAT;
      e.p0  = r0;
      e.p1  = r1;
      e.go  = rgo;
      e.win = rwin;
      exp_q.push_back(e);
    end
    repeat (12) @(posedge clk);
    #2;
    btn_vec = btn_vec & ~mask;
    repeat (12) @(posedge clk);
    drain(name);
  endtask

  initial begin
    exp_t e;
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    rst      = 1'b0;
    btn_vec  = 3'b000;

    // Reset held while all buttons toggle
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      btn_vec = (i % 2 == 0) ? 3'b111 : 3'b000;
    end
    @(negedge clk);
    check_score("reset", 2'd0, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    btn_vec = 3'b000;
    rst     = 1'b1;
    mon_en  = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_score("reset_hold", 2'd0, 2'd0, 1'b0, 1'b0);

    // Clean press held for 20 cycles, then released
    @(posedge clk);
    #2;
    btn_vec[0] = 1'b1;
    e.cyc = cyc + LAT; e.p0 = 2'd1; e.p1 = 2'd0; e.go = 1'b0; e.win = 1'b0;
    exp_q.push_back(e);
    repeat (20) @(posedge clk);
    #2;
    btn_vec[0] = 1'b0;
    repeat (20) @(posedge clk);
    drain("clean");
    check_val("clean_p0", p0, 2'd1);

    // Bounce on btn1: 2-cycle runs never outlast the debounce window
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #2;
      btn_vec[1] = ~btn_vec[1];
      @(posedge clk);
    end
    #2;
    btn_vec[1] = 1'b0;
    repeat (20) @(posedge clk);
    check_val("bounce_p1", p1, 2'd0);

    // Simultaneous points cancel
    press("simul", 3'b011, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    check_score("simul", 2'd1, 2'd0, 1'b0, 1'b0);

    // Reach 2-1, then new game together with a player 0 point
    press("to_2_0", 3'b001, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0);
    press("to_2_1", 3'b010, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0);
    press("new_prio", 3'b101, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    check_score("new_prio", 2'd0, 2'd0, 1'b0, 1'b0);

    // Player 1 wins, then further points are locked out
    press("win_1", 3'b010, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0);
    press("win_2", 3'b010, 1'b1, 2'd0, 2'd2, 1'b0, 1'b0);
    press("win_3", 3'b010, 1'b1, 2'd0, 2'd3, 1'b1, 1'b1);
    press("lock_b0", 3'b001, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    press("lock_b1", 3'b010, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    check_score("lockout", 2'd0, 2'd3, 1'b1, 1'b1);

    // New game clears the finished game; then player 0 wins 3-0
    press("new_game", 3'b100, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    press("p0w_1", 3'b001, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0);
    press("p0w_2", 3'b001, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0);
    press("p0w_3", 3'b001, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0);
    press("new_game2", 3'b100, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);

    // Reach 2-2, then reset with a btn0 press half-debounced
    press("mid_1", 3'b001, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0);
    press("mid_2", 3'b010, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0);
    press("mid_3", 3'b001, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0);
    press("mid_4", 3'b010, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    btn_vec[0] = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    e.cyc = cyc; e.p0 = 2'd0; e.p1 = 2'd0; e.go = 1'b0; e.win = 1'b0;
    exp_q.push_back(e);
    #1;
    check_score("rst_async", 2'd0, 2'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    e.cyc = cyc + LAT; e.p0 = 2'd1; e.p1 = 2'd0; e.go = 1'b0; e.win = 1'b0;
    exp_q.push_back(e);
    repeat (15) @(posedge clk);
    #2;
    btn_vec[0] = 1'b0;
    repeat (15) @(posedge clk);
    drain("rst_mid");
    check_score("rst_mid", 2'd1, 2'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
